// File: rtl/tdm_demux_1to8_pkg.sv
// Shared types and constants for the 8-channel TDM receive demux.
package tdm_pkg;

  localparam int unsigned N_CH  = 8;
  localparam int unsigned SEL_W = 3;
  localparam int unsigned ERR_W = 8;

  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } state_t;

  typedef logic [SEL_W-1:0] sel_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/tdm_demux_1to8_if.sv
// Serial TDM link: one sample per valid cycle, sync marks channel 0.
interface tdm_link_if #(
  parameter int unsigned WIDTH = 1
);

  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             sync;

  modport master (output din, din_valid, sync);
  modport slave  (input  din, din_valid, sync);

endinterface

// File: rtl/tdm_demux_1to8_ctrl.sv
// Frame alignment control for the TDM demux: HUNT/LOCK FSM, channel
// pointer, misplaced-sync detection and the optional error counter.
// Optional feature: define TDM_DEMUX_ERRCNT_EN to keep a live err_cnt.
module tdm_demux_ctrl
  import tdm_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             din_valid,
  input  logic             sync,
  output sel_t             ch_sel,
  output logic             locked,
  output logic             wr_en,
  output sel_t             wr_sel,
  output logic             commit,
  output logic             sync_err,
  output logic [ERR_W-1:0] err_cnt
);

  state_t state;
  logic   restart;
  logic   misplaced;

  assign locked = (state == LOCK);

  // Decode this cycle's shadow write, frame restart and frame commit.
  always_comb begin
    wr_en     = 1'b0;
    wr_sel    = ch_sel;
    commit    = 1'b0;
    restart   = 1'b0;
    misplaced = 1'b0;
    if (din_valid) begin
      if (state == HUNT) begin
        if (sync) begin
          wr_en   = 1'b1;
          wr_sel  = '0;
          restart = 1'b1;
        end
      end else begin
        wr_en = 1'b1;
        if (sync && ch_sel != '0) begin
          misplaced = 1'b1;
          restart   = 1'b1;
          wr_sel    = '0;
        end else begin
          commit = (ch_sel == sel_t'(N_CH - 1));
        end
      end
    end
  end

  // FSM state, channel pointer and the sync-error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= HUNT;
      ch_sel   <= '0;
      sync_err <= 1'b0;
    end else begin
      sync_err <= misplaced;
      if (restart) begin
        state  <= LOCK;
        ch_sel <= sel_t'(1);
      end else if (wr_en) begin
        ch_sel <= ch_sel + 1'b1;
      end
    end
  end

`ifdef TDM_DEMUX_ERRCNT_EN
  // Saturating count of misplaced syncs.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (misplaced) begin
      err_cnt <= sat_inc(err_cnt);
    end
  end
`else
  assign err_cnt = '0;
`endif

endmodule

// File: rtl/tdm_demux_1to8.sv
// 1:8 TDM receive demux: steers serial samples into channel slots and
// presents complete frames on a double-buffered parallel output.
// Optional feature: define TDM_DEMUX_ERRCNT_EN to keep a live err_cnt.
module tdm_demux_1to8
  import tdm_pkg::*;
#(
  parameter int unsigned WIDTH = 1
)(
  input  logic                  clk,
  input  logic                  rst,
  tdm_link_if.slave             link,
  output logic [SEL_W-1:0]      ch_sel,
  output logic                  locked,
  output logic [N_CH*WIDTH-1:0] y,
  output logic                  frame_vld,
  output logic                  sync_err,
  output logic [ERR_W-1:0]      err_cnt
);

  logic             wr_en;
  sel_t             wr_sel;
  logic             commit;
  logic [WIDTH-1:0] shadow [N_CH];

  tdm_demux_ctrl u_ctrl (
    .clk       (clk),
    .rst       (rst),
    .din_valid (link.din_valid),
    .sync      (link.sync),
    .ch_sel    (ch_sel),
    .locked    (locked),
    .wr_en     (wr_en),
    .wr_sel    (wr_sel),
    .commit    (commit),
    .sync_err  (sync_err),
    .err_cnt   (err_cnt)
  );

  // Shadow bank collects the frame currently being received.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        shadow[i] <= '0;
      end
    end else if (wr_en) begin
      shadow[wr_sel] <= link.din;
    end
  end

  // Output bank: last channel bypasses the shadow so y lands on the ch7 edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      y         <= '0;
      frame_vld <= 1'b0;
    end else begin
      frame_vld <= commit;
      if (commit) begin
        for (int unsigned i = 0; i < N_CH - 1; i++) begin
          y[i*WIDTH +: WIDTH] <= shadow[i];
        end
        y[(N_CH-1)*WIDTH +: WIDTH] <= link.din;
      end
    end
  end

endmodule
